// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks: scan FSM states
// and active-low segment patterns (bit order g..a).
package seg_pkg;

    localparam int unsigned STATE_W = 2;

    localparam logic [STATE_W-1:0] SEEK  = 2'd0;
    localparam logic [STATE_W-1:0] SHOW  = 2'd1;
    localparam logic [STATE_W-1:0] BLANK = 2'd2;

    localparam logic [6:0] HEX_0 = 7'h40;
    localparam logic [6:0] HEX_1 = 7'h79;
    localparam logic [6:0] HEX_2 = 7'h24;
    localparam logic [6:0] HEX_3 = 7'h30;
    localparam logic [6:0] HEX_4 = 7'h19;
    localparam logic [6:0] HEX_5 = 7'h12;
    localparam logic [6:0] HEX_6 = 7'h02;
    localparam logic [6:0] HEX_7 = 7'h78;
    localparam logic [6:0] HEX_8 = 7'h00;
    localparam logic [6:0] HEX_9 = 7'h10;
    localparam logic [6:0] HEX_A = 7'h08;
    localparam logic [6:0] HEX_B = 7'h03;
    localparam logic [6:0] HEX_C = 7'h46;
    localparam logic [6:0] HEX_D = 7'h21;
    localparam logic [6:0] HEX_E = 7'h06;
    localparam logic [6:0] HEX_F = 7'h0E;

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment pattern (bits g..a).
module seg_hex_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg_c
);

    always_comb begin
        seg_c = 7'h7F;
        case (nibble)
            4'h0: seg_c = HEX_0;
            4'h1: seg_c = HEX_1;
            4'h2: seg_c = HEX_2;
            4'h3: seg_c = HEX_3;
            4'h4: seg_c = HEX_4;
            4'h5: seg_c = HEX_5;
            4'h6: seg_c = HEX_6;
            4'h7: seg_c = HEX_7;
            4'h8: seg_c = HEX_8;
            4'h9: seg_c = HEX_9;
            4'hA: seg_c = HEX_A;
            4'hB: seg_c = HEX_B;
            4'hC: seg_c = HEX_C;
            4'hD: seg_c = HEX_D;
            4'hE: seg_c = HEX_E;
            4'hF: seg_c = HEX_F;
            default: seg_c = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scanner for an 8-digit common-anode display with a dark
// gap between digits; disabled digits are skipped and take no time slot.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seg_en,
    input  logic [3:0] num1,
    input  logic [3:0] num2,
    input  logic [3:0] num3,
    input  logic [3:0] num4,
    input  logic [3:0] num5,
    input  logic [3:0] num6,
    input  logic [3:0] num7,
    input  logic [3:0] num8,
    input  logic [7:0] dp,
    output logic [7:0] seg,
    output logic [7:0] sel
);

    localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
    localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    logic [STATE_W-1:0] state, state_nxt;
    logic [2:0]         idx, idx_nxt;
    logic [PRE_W-1:0]   prescaler, prescaler_nxt;
    logic [BLK_W-1:0]   blank_cnt, blank_cnt_nxt;
    logic [7:0]         seg_nxt, sel_nxt;
    logic [3:0]         nums [8];
    logic [6:0]         hex_seg;
    logic [2:0]         next_en_idx;
    logic               found;
    logic               any_en;

    assign nums[0] = num1;
    assign nums[1] = num2;
    assign nums[2] = num3;
    assign nums[3] = num4;
    assign nums[4] = num5;
    assign nums[5] = num6;
    assign nums[6] = num7;
    assign nums[7] = num8;
    assign any_en  = ~&seg_en;

    seg_hex_decode u_hex (
        .nibble (nums[idx]),
        .seg_c  (hex_seg)
    );

    // First enabled digit after idx, wrapping, with idx itself considered last.
    always_comb begin
        next_en_idx = idx;
        found       = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            if (!found && !seg_en[idx + 3'(i)]) begin
                next_en_idx = idx + 3'(i);
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        prescaler_nxt = prescaler;
        blank_cnt_nxt = blank_cnt;
        seg_nxt       = 8'hFF;
        sel_nxt       = 8'hFF;
        case (state)
            SEEK: begin
                if (any_en) begin
                    idx_nxt       = next_en_idx;
                    prescaler_nxt = '0;
                    state_nxt     = SHOW;
                end
            end
            SHOW: begin
                seg_nxt = {~dp[idx], hex_seg};
                sel_nxt = ~(8'd1 << idx);
                // A digit disabled mid-slot is cut short immediately.
                if (seg_en[idx] || (prescaler == PRE_LAST)) begin
                    if (BLANK_CYCLES == 0) begin
                        state_nxt = SEEK;
                    end else begin
                        state_nxt     = BLANK;
                        blank_cnt_nxt = BLK_LOAD;
                    end
                end else begin
                    prescaler_nxt = prescaler + PRE_W'(1);
                end
            end
            BLANK: begin
                if (blank_cnt == '0) begin
                    state_nxt = SEEK;
                end else begin
                    blank_cnt_nxt = blank_cnt - BLK_W'(1);
                end
            end
            default: state_nxt = SEEK;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SEEK;
            idx       <= 3'd7;
            prescaler <= '0;
            blank_cnt <= '0;
            seg       <= 8'hFF;
            sel       <= 8'hFF;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            prescaler <= prescaler_nxt;
            blank_cnt <= blank_cnt_nxt;
            seg       <= seg_nxt;
            sel       <= sel_nxt;
        end
    end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed scanner for the 8-digit common-anode seven-segment display. It takes eight 4-bit digit values, a per-digit enable mask and per-digit decimal points, and drives the shared active-low segment and digit-select lines one digit at a time. A blanking gap between digits suppresses ghosting. It sits directly downstream of the BCD counter chain and replaces free-running scan logic in the display top level.

Parameters:
SCAN_DIV, 100000, clk cycles each digit is lit (1 ms at 100 MHz); must be >= 1
BLANK_CYCLES, 1000, clk cycles all digits are dark between digits; 0 disables blanking

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
seg_en  input  8  per-digit enable, 0 = enabled, 1 = disabled; bit i gates digit i
num1..num8  input  4 each  digit values; num(i+1) drives digit index i / sel[i]
dp  input  8  decimal point per digit, 1 = lit
seg  output  8  active-low segments; seg[0]=a … seg[6]=g, seg[7]=dp
sel  output  8  active-low digit select, one-hot-low or all 1

Behaviour:
- Reset (asynchronous, active-high): seg=8'hFF, sel=8'hFF, state=SEEK, idx=7, prescaler=0, blank counter=0. Outputs go to FF immediately on reset assertion, not at the next edge.
- States:
  - SEEK: lasts 1 cycle when any digit is enabled. idx <= next enabled index after idx, cyclic 0→7, with idx itself checked last. State -> SHOW and prescaler cleared. If seg_en==8'hFF, stay in SEEK with idx unchanged.
  - SHOW: prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1, go to BLANK (blank counter loaded with BLANK_CYCLES-1), or to SEEK if BLANK_CYCLES==0.
  - BLANK: blank counter decrements; at 0, go to SEEK.
- Abort: if seg_en[idx] becomes 1 while in SHOW, the next state is BLANK (or SEEK if BLANK_CYCLES==0) regardless of prescaler.
- Outputs are registered, updated every clk:
  - SHOW: sel <= ~(1<<idx); seg <= {~dp[idx], hex7(num[idx])}.
  - Otherwise: sel <= FF, seg <= FF.
  - Result: one-cycle latency from state/inputs to pins. A num or dp change during SHOW appears on seg exactly 1 cycle later.
- Per-digit period = 1 + SCAN_DIV + BLANK_CYCLES cycles. Disabled digits take no time slot.
- hex7 encoding (active-low, bits g..a), shown as full seg with dp off: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E.
- Counter widths: $clog2 of the parameter, minimum 1 bit. Counters never wrap past their terminal value.
- Never more than one sel bit low at a time. During SEEK and BLANK, sel==FF.

Decomposition:
- Shared package seg_pkg: state enum (SEEK, SHOW, BLANK) and the 16 active-low segment constants.
- One sub-module, seg_hex_decode: combinational nibble -> 7-bit active-low segments, also reusable by other display blocks.
- Prescaler, blank counter, next-enabled-index priority logic and FSM live in seg_scan_driver.

Test Plan:
- Test parameters: SCAN_DIV=4, BLANK_CYCLES=2 (7-cycle slot).
- Reset: assert reset mid-SHOW -> seg=FF, sel=FF before the next clk edge. Release -> first sel low 2 edges later, on sel[0] if seg_en[0]=0.
- Normal scan: seg_en=8'b11000011, num3=1, num4=2, num5=3, num6=4, dp=0 -> sel cycles FB, F7, EF, DF, each low for 4 cycles with 3 FF cycles between. seg shows F9, A4, B0, 99 respectively, FF in the gaps.
- All disabled: seg_en=FF -> sel=FF and seg=FF indefinitely. Then set seg_en=8'hFE -> sel=FE within 2 cycles.
- Single digit with dp: seg_en=8'h7F, num8=F, dp[7]=1 -> sel=7F, seg=0E for 4 of every 7 cycles.
- Abort: in SHOW on digit 2, set seg_en[2]=1 -> sel=FF 2 cycles later; the next slot skips to the next enabled digit.
- Live update: change num3 from 1 to 8 mid-SHOW -> seg changes F9→80 exactly 1 cycle later, sel unchanged.
